// File: rtl/data_mem_bytelane_pkg.sv
// Shared definitions for the RV32I byte-lane data memory: funct3 access
// encodings and the clear/run state type.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

endpackage

// File: rtl/data_mem_bytelane_if.sv
// Load/store bus between the core (master) and the data memory (slave).
interface data_mem_bytelane_if #(
    parameter int AW = 32
);
    logic          we;
    logic [2:0]    funct3;
    logic [AW-1:0] A;
    logic [31:0]   WD;
    logic [31:0]   RD;
    logic          ready;
    logic          err;

    modport master (output we, funct3, A, WD, input RD, ready, err);
    modport slave  (input we, funct3, A, WD, output RD, ready, err);
endinterface

// File: rtl/data_mem_bytelane_lane_align.sv
// Byte-lane steering: load lane select with sign/zero extension, store
// byte enables with replicated data, and alignment/legality decode.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        isStore,
    input  logic [31:0] rword,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] shifted;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign shifted = rword >> {off, 3'b000};
    assign byteSel = shifted[7:0];
    assign halfSel = off[1] ? rword[31:16] : rword[15:0];

    // Unsigned loads have no store counterpart, so they are illegal on the store side.
    always_comb begin
        rd       = '0;
        be       = '0;
        wdata    = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (funct3)
            F3_B: begin
                rd    = {{24{byteSel[7]}}, byteSel};
                be    = 4'b0001 << off;
                wdata = {4{wd[7:0]}};
            end
            F3_BU: begin
                rd      = {24'b0, byteSel};
                illegal = isStore;
            end
            F3_H: begin
                rd       = {{16{halfSel[15]}}, halfSel};
                be       = off[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{wd[15:0]}};
                misalign = off[0];
            end
            F3_HU: begin
                rd       = {16'b0, halfSel};
                misalign = off[0];
                illegal  = isStore;
            end
            F3_W: begin
                rd       = rword;
                be       = 4'b1111;
                wdata    = wd;
                misalign = |off;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_bytelane.sv
// RV32I data memory with byte/halfword/word access, range checking and a
// one-word-per-clock clear sequencer that holds ready low until done.
module data_mem_bytelane
    import mem_pkg::*;
#(
    parameter int DEPTH          = 16000,
    parameter int AW             = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic                clk,
    input logic                rst,
    data_mem_bytelane_if.slave bus
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [DEPTH];
    state_t        state;
    logic [IW-1:0] cnt;
    logic          readyQ;

    logic [AW-3:0] wordIdx;
    logic [IW-1:0] memIdx;
    logic          inRange;
    logic [31:0]   rword;
    logic [31:0]   alignRd;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          misalign;
    logic          illegal;
    logic          errRun;
    logic          clrEn;
    logic          storeEn;

    assign wordIdx = bus.A[AW-1:2];
    assign memIdx  = wordIdx[IW-1:0];
    assign inRange = wordIdx < (AW-2)'(DEPTH);
    assign rword   = inRange ? mem[memIdx] : '0;

    mem_lane_align u_align (
        .funct3   (bus.funct3),
        .off      (bus.A[1:0]),
        .isStore  (bus.we),
        .rword    (rword),
        .wd       (bus.WD),
        .rd       (alignRd),
        .be       (be),
        .wdata    (wdata),
        .misalign (misalign),
        .illegal  (illegal)
    );

    assign errRun    = misalign || illegal || !inRange;
    assign bus.err   = (state == S_RUN) && errRun;
    assign bus.RD    = (state == S_RUN && !errRun) ? alignRd : '0;
    assign bus.ready = readyQ;

    // Writes are blocked while rst is held so a store racing reset never lands.
    assign clrEn   = !rst && (state == S_CLEAR);
    assign storeEn = !rst && (state == S_RUN) && bus.we && !errRun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            cnt    <= '0;
            readyQ <= !CLEAR_ON_RESET;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (cnt == IW'(DEPTH - 1)) begin
                        state  <= S_RUN;
                        readyQ <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clrEn) begin
            mem[cnt] <= '0;
        end else if (storeEn) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[memIdx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
